battleship_turn_controller: RTL and testbench
=============================================

// Module: battleship_turn_controller
// PURPOSE
//  Turn sequencer for the 5x5 battleship game. Drives the one-hot game-state flags consumed by the game
//  logic (start/play/pc/win/lose), issues board-generation and shot strobes, and latches shot coordinates.
//  Counts remaining ship cells per side from board hit responses, enforces a player-turn timeout and a
//  PC "think" delay. Sits between the switch/button front end and the game-logic/board datapath.
// PARAMETERS
//  SHIP_CELLS    5           ship cells per board; side loses when its count reaches 0
//  TURN_TIMEOUT  500_000_000 cycles the player may idle in its turn before forfeiting it
//  PC_DELAY      50_000_000  cycles spent in PC turn before the PC shot strobe
//  CNT_W         30          width of shared cycle counter (must hold max(TURN_TIMEOUT,PC_DELAY))
// PORTS
//  clk              in   1      system clock
//  rst              in   1      asynchronous, active-low reset
//  select_btn       in   1      select button level, already synchronised and debounced
//  row_coord        in   3      player shot row from switches
//  col_coord        in   3      player shot column from switches
//  pc_board_hit     in   1      PC board reply, valid the cycle after player_shoot: 1 = new hit
//  player_board_hit in   1      player board reply, valid the cycle after pc_shoot: 1 = new hit
//  start_state      out  1      one-hot state flag: waiting to start
//  play_state       out  1      one-hot state flag: player turn (incl. fire/check)
//  pc_state         out  1      one-hot state flag: PC turn (incl. fire/check)
//  win_state        out  1      one-hot state flag: player won
//  lose_state       out  1      one-hot state flag: player lost
//  gen_boards       out  1      1-cycle strobe: generate both boards
//  player_shoot     out  1      1-cycle strobe: fire at PC board with shot_row/shot_col
//  pc_shoot         out  1      1-cycle strobe: PC fires at player board (coords from its own RNG)
//  shot_row         out  3      latched player shot row
//  shot_col         out  3      latched player shot column
//  pc_cells_left    out  3      remaining PC ship cells
//  player_cells_left out 3      remaining player ship cells
//  turn_timer       out  CNT_W  current value of the cycle counter (for display)
// BEHAVIOUR
//  Reset (rst=0, async): state=S_START; start_state=1, other flags 0; all strobes 0; shot_row/col=0;
//   counter=0; both cells_left=SHIP_CELLS; select edge register=0. Applies mid-game from any state.
//  sel_rise = select_btn & ~select_btn_q (registered previous level); only rising edges act.
//  States / transitions (all outputs registered; strobes high exactly one cycle):
//   S_START : sel_rise -> S_GEN.
//   S_GEN   : gen_boards=1; reload cells_left=SHIP_CELLS; counter=0 -> S_PLAYER.
//   S_PLAYER: counter++ each cycle. sel_rise with row_coord<5 and col_coord<5 -> latch coords, S_PFIRE.
//             sel_rise with coord>=5 ignored (stay, counter keeps running).
//             counter==TURN_TIMEOUT-1 without valid sel_rise -> turn forfeited, counter=0, S_PC.
//             Valid sel_rise in the same cycle as timeout: the shot wins (-> S_PFIRE).
//   S_PFIRE : player_shoot=1 -> S_PCHK.
//   S_PCHK  : if pc_board_hit: pc_cells_left-- ; if it becomes 0 -> S_WIN, else -> S_PC. counter=0.
//   S_PC    : counter++; counter==PC_DELAY-1 -> S_CFIRE. sel_rise ignored.
//   S_CFIRE : pc_shoot=1 -> S_CCHK.
//   S_CCHK  : if player_board_hit: player_cells_left-- ; 0 -> S_LOSE, else counter=0, S_PLAYER.
//   S_WIN/S_LOSE: hold flags and counts; sel_rise -> S_START.
//  Flag mapping: play_state in S_PLAYER/S_PFIRE/S_PCHK; pc_state in S_PC/S_CFIRE/S_CCHK;
//   start_state in S_START/S_GEN. Exactly one flag high at all times.
//  Counts saturate at 0 (never wrap); hit inputs ignored outside S_PCHK/S_CCHK.
//  Latency: valid sel_rise in S_PLAYER -> player_shoot 1 cycle later; win_state 3 cycles after sel_rise
//   on the final hit. Button held high across states produces no further action until released.
// TESTING (small params: SHIP_CELLS=2, TURN_TIMEOUT=20, PC_DELAY=4)
//  Reset then select pulse -> gen_boards one cycle, play_state=1, both cells_left=2.
//  In player turn, row=2,col=3, select -> player_shoot 1 cycle, shot_row=2, shot_col=3; hit=1 -> pc_cells_left=1, pc_state=1.
//  row=5 select -> no player_shoot, stays play_state; idle 20 cycles -> pc_state=1, pc_cells_left unchanged.
//  PC turn -> pc_shoot exactly 4 cycles after entry; two player_board_hit replies over two rounds -> lose_state=1.
//  Two player hits -> win_state=1; select -> start_state=1; select held high -> only one gen_boards.
//  rst=0 asserted during S_PC -> immediately start_state=1, counts=2, no strobe on release.

Source files
------------

// File: rtl/battleship_turn_controller.sv
// Turn sequencer for the 5x5 battleship game: one-hot game-state flags, board/shot strobes,
// shot-coordinate latch, per-side ship-cell counters and the shared turn/think cycle counter.
module battleship_turn_controller #(
   parameter int SHIP_CELLS   = 5,
   parameter int TURN_TIMEOUT = 500_000_000,
   parameter int PC_DELAY     = 50_000_000,
   parameter int CNT_W        = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             select_btn,
   input  logic [2:0]       row_coord,
   input  logic [2:0]       col_coord,
   input  logic             pc_board_hit,
   input  logic             player_board_hit,
   output logic             start_state,
   output logic             play_state,
   output logic             pc_state,
   output logic             win_state,
   output logic             lose_state,
   output logic             gen_boards,
   output logic             player_shoot,
   output logic             pc_shoot,
   output logic [2:0]       shot_row,
   output logic [2:0]       shot_col,
   output logic [2:0]       pc_cells_left,
   output logic [2:0]       player_cells_left,
   output logic [CNT_W-1:0] turn_timer
);

   localparam logic [3:0] S_START  = 4'd0;
   localparam logic [3:0] S_GEN    = 4'd1;
   localparam logic [3:0] S_PLAYER = 4'd2;
   localparam logic [3:0] S_PFIRE  = 4'd3;
   localparam logic [3:0] S_PCHK   = 4'd4;
   localparam logic [3:0] S_PC     = 4'd5;
   localparam logic [3:0] S_CFIRE  = 4'd6;
   localparam logic [3:0] S_CCHK   = 4'd7;
   localparam logic [3:0] S_WIN    = 4'd8;
   localparam logic [3:0] S_LOSE   = 4'd9;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TURN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PC_LAST      = CNT_W'(PC_DELAY - 1);
   localparam logic [2:0]       CELLS        = 3'(SHIP_CELLS);

   logic [3:0]       state, nextState;
   logic             selQ, selRise, coordOk, shotTaken;
   logic [CNT_W-1:0] counter;

   assign selRise   = select_btn & ~selQ;
   assign coordOk   = (row_coord < 3'd5) && (col_coord < 3'd5);
   assign shotTaken = (state == S_PLAYER) && selRise && coordOk;
   assign turn_timer = counter;

   always_comb begin
      nextState = state;
      case (state)
         S_START:  if (selRise) nextState = S_GEN;
         S_GEN:    nextState = S_PLAYER;
         // a valid shot takes priority over a timeout landing in the same cycle
         S_PLAYER: if (shotTaken) nextState = S_PFIRE;
                   else if (counter == TIMEOUT_LAST) nextState = S_PC;
         S_PFIRE:  nextState = S_PCHK;
         S_PCHK:   nextState = (pc_board_hit && pc_cells_left <= 3'd1) ? S_WIN : S_PC;
         S_PC:     if (counter == PC_LAST) nextState = S_CFIRE;
         S_CFIRE:  nextState = S_CCHK;
         S_CCHK:   nextState = (player_board_hit && player_cells_left <= 3'd1) ? S_LOSE : S_PLAYER;
         S_WIN,
         S_LOSE:   if (selRise) nextState = S_START;
         default:  nextState = S_START;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= S_START;
         selQ              <= 1'b0;
         counter           <= '0;
         shot_row          <= 3'd0;
         shot_col          <= 3'd0;
         pc_cells_left     <= CELLS;
         player_cells_left <= CELLS;
         start_state       <= 1'b1;
         play_state        <= 1'b0;
         pc_state          <= 1'b0;
         win_state         <= 1'b0;
         lose_state        <= 1'b0;
         gen_boards        <= 1'b0;
         player_shoot      <= 1'b0;
         pc_shoot          <= 1'b0;
      end else begin
         state <= nextState;
         selQ  <= select_btn;

         // counter runs only while staying in a timed state; every transition clears it
         if ((state == S_PLAYER || state == S_PC) && nextState == state)
            counter <= counter + CNT_W'(1);
         else
            counter <= '0;

         if (shotTaken) begin
            shot_row <= row_coord;
            shot_col <= col_coord;
         end

         if (state == S_GEN) begin
            pc_cells_left     <= CELLS;
            player_cells_left <= CELLS;
         end else begin
            if (state == S_PCHK && pc_board_hit && pc_cells_left != 3'd0)
               pc_cells_left <= pc_cells_left - 3'd1;
            if (state == S_CCHK && player_board_hit && player_cells_left != 3'd0)
               player_cells_left <= player_cells_left - 3'd1;
         end

         start_state  <= (nextState == S_START) || (nextState == S_GEN);
         play_state   <= (nextState == S_PLAYER) || (nextState == S_PFIRE) || (nextState == S_PCHK);
         pc_state     <= (nextState == S_PC) || (nextState == S_CFIRE) || (nextState == S_CCHK);
         win_state    <= (nextState == S_WIN);
         lose_state   <= (nextState == S_LOSE);
         gen_boards   <= (nextState == S_GEN);
         player_shoot <= (nextState == S_PFIRE);
         pc_shoot     <= (nextState == S_CFIRE);
      end
   end

endmodule

// File: tb/tb_battleship_turn_controller.sv
// Bench for battleship_turn_controller with small game parameters; strobes are checked
// against a queue of expected events, flags and counts inline in each scenario task.
module tb_battleship_turn_controller;

   localparam int CNT_W = 8;

   typedef struct {
      int         kind;   // 0 gen_boards, 1 player_shoot, 2 pc_shoot
      logic [2:0] row;
      logic [2:0] col;
   } evt_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             select_btn = 1'b0;
   logic [2:0]       row_coord = 3'd0, col_coord = 3'd0;
   logic             pc_board_hit = 1'b0, player_board_hit = 1'b0;
   logic             start_state, play_state, pc_state, win_state, lose_state;
   logic             gen_boards, player_shoot, pc_shoot;
   logic [2:0]       shot_row, shot_col, pc_cells_left, player_cells_left;
   logic [CNT_W-1:0] turn_timer;

   int   nChk = 0;
   int   nFail = 0;
   int   expPc = 2, expPl = 2;
   evt_t expQ[$];

   battleship_turn_controller #(.SHIP_CELLS(2), .TURN_TIMEOUT(20), .PC_DELAY(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .select_btn(select_btn), .row_coord(row_coord), .col_coord(col_coord),
      .pc_board_hit(pc_board_hit), .player_board_hit(player_board_hit),
      .start_state(start_state), .play_state(play_state), .pc_state(pc_state),
      .win_state(win_state), .lose_state(lose_state), .gen_boards(gen_boards),
      .player_shoot(player_shoot), .pc_shoot(pc_shoot), .shot_row(shot_row), .shot_col(shot_col),
      .pc_cells_left(pc_cells_left), .player_cells_left(player_cells_left), .turn_timer(turn_timer)
   );

   always #5 clk = ~clk;

   // strobe scoreboard plus one-hot flag check, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         nChk++;
         if ($countones({start_state, play_state, pc_state, win_state, lose_state}) !== 1) begin
            nFail++;
            $display("FAIL onehot: flags=%b required exactly one high",
                     {start_state, play_state, pc_state, win_state, lose_state});
         end
         if (gen_boards || player_shoot || pc_shoot) begin
            nChk++;
            if (expQ.size() == 0) begin
               nFail++;
               $display("FAIL strobe_unexpected: gen=%b pshoot=%b cshoot=%b required none at %0t",
                        gen_boards, player_shoot, pc_shoot, $time);
            end else begin
               evt_t e;
               e = expQ.pop_front();
               if ({gen_boards, player_shoot, pc_shoot} !== (3'b100 >> e.kind) ||
                   (e.kind == 1 && (shot_row !== e.row || shot_col !== e.col))) begin
                  nFail++;
                  $display("FAIL strobe_kind: gen/pshoot/cshoot=%b row=%0d col=%0d required kind %0d row=%0d col=%0d",
                           {gen_boards, player_shoot, pc_shoot}, shot_row, shot_col, e.kind, e.row, e.col);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press();
      select_btn = 1'b1;
      step(1);
      select_btn = 1'b0;
   endtask

   task automatic push(input int kind, input logic [2:0] r, input logic [2:0] c);
      evt_t e;
      e.kind = kind; e.row = r; e.col = c;
      expQ.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(2);
      nChk++;
      if ({start_state, play_state, pc_state, win_state, lose_state, gen_boards, player_shoot, pc_shoot} !== 8'b1000_0000 ||
          shot_row !== 3'd0 || shot_col !== 3'd0 || turn_timer !== '0 ||
          pc_cells_left !== 3'd2 || player_cells_left !== 3'd2) begin
         nFail++;
         $display("FAIL reset_state: flags=%b shot=%0d,%0d timer=%0d cells=%0d/%0d required 10000000 0,0 0 2/2",
                  {start_state, play_state, pc_state, win_state, lose_state, gen_boards, player_shoot, pc_shoot},
                  shot_row, shot_col, turn_timer, pc_cells_left, player_cells_left);
      end
      rst = 1'b1;
      step(2);
      nChk++;
      if (start_state !== 1'b1) begin
         nFail++;
         $display("FAIL reset_release: start_state=%b required 1", start_state);
      end
   endtask

   // from S_START: a press (optionally held for extra cycles) generates boards once
   task automatic test_start(input int holdExtra);
      push(0, 3'd0, 3'd0);
      select_btn = 1'b1;
      step(1);
      nChk++;
      if (start_state !== 1'b1 || gen_boards !== 1'b1) begin
         nFail++;
         $display("FAIL gen_state: start_state=%b gen_boards=%b required 1 1", start_state, gen_boards);
      end
      step(1 + holdExtra);
      select_btn = 1'b0;
      expPc = 2; expPl = 2;
      nChk++;
      if (play_state !== 1'b1 || pc_cells_left !== 3'(expPc) || player_cells_left !== 3'(expPl)) begin
         nFail++;
         $display("FAIL enter_play: play_state=%b cells=%0d/%0d required 1 %0d/%0d",
                  play_state, pc_cells_left, player_cells_left, expPc, expPl);
      end
      step(1);
   endtask

   task automatic test_player_shot(input logic [2:0] r, input logic [2:0] c, input logic hit);
      row_coord = r; col_coord = c;
      push(1, r, c);
      press();
      nChk++;
      if (play_state !== 1'b1 || player_shoot !== 1'b1 || shot_row !== r || shot_col !== c) begin
         nFail++;
         $display("FAIL player_fire: play=%b shoot=%b shot=%0d,%0d required 1 1 %0d,%0d",
                  play_state, player_shoot, shot_row, shot_col, r, c);
      end
      step(1);
      pc_board_hit = hit;
      if (hit && expPc > 0) expPc--;
      step(1);
      pc_board_hit = 1'b0;
      nChk++;
      if (pc_cells_left !== 3'(expPc) || win_state !== (expPc == 0) || pc_state !== (expPc != 0)) begin
         nFail++;
         $display("FAIL player_check: pc_cells=%0d win=%b pc=%b required %0d %b %b",
                  pc_cells_left, win_state, pc_state, expPc, expPc == 0, expPc != 0);
      end
   endtask

   // entered at the first S_PC cycle; pc_shoot must appear exactly PC_DELAY cycles later
   task automatic test_pc_turn(input logic hit);
      push(2, 3'd0, 3'd0);
      select_btn = 1'b1;   // presses during the PC turn are ignored
      step(3);
      select_btn = 1'b0;
      nChk++;
      if (pc_shoot !== 1'b0 || pc_state !== 1'b1 || turn_timer !== 8'd3) begin
         nFail++;
         $display("FAIL pc_think: pc_shoot=%b pc_state=%b timer=%0d required 0 1 3", pc_shoot, pc_state, turn_timer);
      end
      step(1);
      nChk++;
      if (pc_shoot !== 1'b1) begin
         nFail++;
         $display("FAIL pc_fire: pc_shoot=%b required 1", pc_shoot);
      end
      step(1);
      player_board_hit = hit;
      if (hit && expPl > 0) expPl--;
      step(1);
      player_board_hit = 1'b0;
      nChk++;
      if (player_cells_left !== 3'(expPl) || lose_state !== (expPl == 0) ||
          play_state !== (expPl != 0) || (expPl != 0 && turn_timer !== '0)) begin
         nFail++;
         $display("FAIL pc_check: pl_cells=%0d lose=%b play=%b timer=%0d required %0d %b %b 0",
                  player_cells_left, lose_state, play_state, turn_timer, expPl, expPl == 0, expPl != 0);
      end
   endtask

   task automatic test_invalid_timeout();
      row_coord = 3'd5; col_coord = 3'd1;
      press();
      row_coord = 3'd1; col_coord = 3'd7;
      press();
      nChk++;
      if (play_state !== 1'b1 || turn_timer !== 8'd2) begin
         nFail++;
         $display("FAIL invalid_coord: play=%b timer=%0d required 1 2", play_state, turn_timer);
      end
      step(17);
      nChk++;
      if (play_state !== 1'b1 || turn_timer !== 8'd19) begin
         nFail++;
         $display("FAIL before_timeout: play=%b timer=%0d required 1 19", play_state, turn_timer);
      end
      step(1);
      nChk++;
      if (pc_state !== 1'b1 || turn_timer !== '0 || pc_cells_left !== 3'(expPc)) begin
         nFail++;
         $display("FAIL timeout: pc=%b timer=%0d pc_cells=%0d required 1 0 %0d",
                  pc_state, turn_timer, pc_cells_left, expPc);
      end
   endtask

   // waits in the player turn until the timeout cycle, then shoots in that very cycle
   task automatic test_timeout_race();
      step(19);
      nChk++;
      if (turn_timer !== 8'd19 || play_state !== 1'b1) begin
         nFail++;
         $display("FAIL race_setup: timer=%0d play=%b required 19 1", turn_timer, play_state);
      end
      test_player_shot(3'd4, 3'd0, 1'b1);
   endtask

   task automatic test_end_hold(input logic isWin);
      pc_board_hit = 1'b1; player_board_hit = 1'b1;
      step(3);
      pc_board_hit = 1'b0; player_board_hit = 1'b0;
      nChk++;
      if (win_state !== isWin || lose_state !== !isWin ||
          pc_cells_left !== 3'(expPc) || player_cells_left !== 3'(expPl)) begin
         nFail++;
         $display("FAIL end_hold: win=%b lose=%b cells=%0d/%0d required %b %b %0d/%0d",
                  win_state, lose_state, pc_cells_left, player_cells_left, isWin, !isWin, expPc, expPl);
      end
      press();
      nChk++;
      if (start_state !== 1'b1) begin
         nFail++;
         $display("FAIL back_to_start: start_state=%b required 1", start_state);
      end
      step(1);
   endtask

   task automatic test_reset_midgame();
      test_start(0);
      test_player_shot(3'd0, 3'd0, 1'b0);
      step(2);
      rst = 1'b0;
      #1;
      nChk++;
      if (start_state !== 1'b1 || pc_state !== 1'b0 || pc_cells_left !== 3'd2 ||
          player_cells_left !== 3'd2 || turn_timer !== '0) begin
         nFail++;
         $display("FAIL async_reset: start=%b pc=%b cells=%0d/%0d timer=%0d required 1 0 2/2 0",
                  start_state, pc_state, pc_cells_left, player_cells_left, turn_timer);
      end
      step(2);
      rst = 1'b1;
      step(8);
      nChk++;
      if (start_state !== 1'b1 || gen_boards !== 1'b0) begin
         nFail++;
         $display("FAIL reset_idle: start=%b gen=%b required 1 0", start_state, gen_boards);
      end
   endtask

   initial begin
      test_reset();
      // game 1: player loses
      test_start(0);
      test_player_shot(3'd2, 3'd3, 1'b1);
      test_pc_turn(1'b1);
      test_invalid_timeout();
      test_pc_turn(1'b0);
      test_player_shot(3'd4, 3'd4, 1'b0);
      test_pc_turn(1'b1);
      test_end_hold(1'b0);
      // game 2: held select, then player wins on a timeout-cycle shot
      test_start(3);
      test_player_shot(3'd1, 3'd2, 1'b1);
      test_pc_turn(1'b0);
      test_timeout_race();
      test_end_hold(1'b1);
      test_reset_midgame();
      nChk++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
